mult_secuencial: RTL and testbench

- Iterative signed fixed-point shift-and-add multiplier, one multiplier bit per clock.
- Sits directly upstream of the two-stage output register in the datapath.
- Resultado drives the register's data input; done drives its enable.
- Busy/done handshake, so the control FSM issues one operation at a time.

---
 rtl/mult_secuencial.sv | 126 ++++++++++++
 tb/tb_mult_secuencial.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_secuencial.sv
// Iterative signed fixed-point shift-and-add multiplier.
// Handles one multiplier bit per clock, then rounds and saturates to Q(W-F).F.
module mult_secuencial #(
  parameter int W = 23,
  parameter int F = 8
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Resultado,
  output logic         overflow
);

  localparam int CW = $clog2(W);
  localparam logic [2*W-1:0] HALF = ((2*W)'(1) << F) >> 1;
  localparam logic [2*W-1:0] MAXP = (2*W)'({1'b0, {(W-1){1'b1}}});
  localparam logic [2*W-1:0] MAXN = (2*W)'({1'b1, {(W-1){1'b0}}});
  localparam logic [W-1:0]   SATP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   SATN = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0]  LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROUND
  } state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplr_q, mplr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic [W-1:0]    res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic [W-1:0]    a_mag, b_mag;
  logic [2*W-1:0]  sum, mag;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1).
  assign a_mag = A[W-1] ? (~A + {{(W-1){1'b0}}, 1'b1}) : A;
  assign b_mag = B[W-1] ? (~B + {{(W-1){1'b0}}, 1'b1}) : B;

  assign sum = acc_q + HALF;
  assign mag = sum >> F;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = A[W-1] ^ B[W-1];
          mcand_d = (2*W)'(a_mag);
          mplr_d  = b_mag;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ROUND;
      end
      ROUND: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (!sign_q) begin
          ovf_d = (mag > MAXP);
          res_d = ovf_d ? SATP : mag[W-1:0];
        end else begin
          // Negating zero yields zero, so no negative-zero special case.
          ovf_d = (mag > MAXN);
          res_d = ovf_d ? SATN
                        : (~mag[W-1:0] + {{(W-1){1'b0}}, 1'b1});
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == CALC) || (state_q == ROUND);
  assign done      = done_q;
  assign Resultado = res_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mult_secuencial.sv
// Directed self-checking bench for mult_secuencial (W=23, F=8).
// Vector table for arithmetic plus hand sequences for handshake corners.
module tb_mult_secuencial;

  localparam int W = 23;
  localparam int F = 8;
  localparam int NV = 14;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done, overflow;
  logic [W-1:0] Resultado;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;

  vec_t vecs [NV];

  always #5 CLK = ~CLK;

  mult_secuencial #(.W(W), .F(F)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .Resultado (Resultado),
    .overflow  (overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
  endtask

  // Counts edges until done, and busy samples along the way.
  task automatic wait_done(output int lat, output int bsy);
    bit found;
    found = 1'b0;
    lat = 0;
    bsy = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (busy) bsy++;
      @(posedge CLK);
      #1;
      lat++;
      if (done) found = 1'b1;
    end
    if (!found) lat = -1;
  endtask

  initial begin
    int lat, bsy, nd, first, k;
    bit got;

    vecs[0]  = '{23'h000300, 23'h000200, 23'h000600, 1'b0};
    vecs[1]  = '{23'h7FFD00, 23'h000200, 23'h7FFA00, 1'b0};
    vecs[2]  = '{23'h000001, 23'h000080, 23'h000001, 1'b0};
    vecs[3]  = '{23'h000001, 23'h00007F, 23'h000000, 1'b0};
    vecs[4]  = '{23'h3FFFFF, 23'h3FFFFF, 23'h3FFFFF, 1'b1};
    vecs[5]  = '{23'h400000, 23'h000100, 23'h400000, 1'b0};
    vecs[6]  = '{23'h400000, 23'h7FFF00, 23'h3FFFFF, 1'b1};
    vecs[7]  = '{23'h7FFF00, 23'h7FFF00, 23'h000100, 1'b0};
    vecs[8]  = '{23'h7FFFFF, 23'h000080, 23'h7FFFFF, 1'b0};
    vecs[9]  = '{23'h400000, 23'h400000, 23'h3FFFFF, 1'b1};
    vecs[10] = '{23'h400000, 23'h7FFFFF, 23'h004000, 1'b0};
    vecs[11] = '{23'h3FFFFF, 23'h7FFF00, 23'h400001, 1'b0};
    vecs[12] = '{23'h3FFFFF, 23'h400000, 23'h400000, 1'b1};
    vecs[13] = '{23'h3FFFFF, 23'h000100, 23'h3FFFFF, 1'b0};

    Reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(Resultado), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(lat, bsy);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd24);
      chk($sformatf("v%0d_busy", i), 32'(bsy), 32'd24);
      chk($sformatf("v%0d_res", i), 32'(Resultado), 32'(vecs[i].res));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_dbusy", i), 32'(busy), 32'd0);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_hold", i), 32'(Resultado), 32'(vecs[i].res));
    end

    // Async reset between edges while a result is held
    @(negedge CLK);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_res", 32'(Resultado), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;

    // start pulsed at CALC cycle 5 is ignored
    issue(23'h000300, 23'h000200);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    A = 23'h000100;
    B = 23'h000100;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    nd = 0;
    first = -1;
    for (int i = 6; i <= 70; i++) begin
      @(posedge CLK);
      #1;
      if (done) begin
        nd++;
        if (first < 0) first = i;
      end
      if (done && nd == 1)
        chk("ign_res", 32'(Resultado), 32'h000600);
    end
    chk("ign_ndone", 32'(nd), 32'd1);
    chk("ign_lat", 32'(first), 32'd24);

    // start held through the done cycle: back-to-back ops
    @(negedge CLK);
    A = 23'h000300;
    B = 23'h000200;
    start = 1'b1;
    @(posedge CLK);
    #1;
    A = 23'h7FFD00;
    B = 23'h7FFD00;
    wait_done(lat, bsy);
    chk("b2b_lat1", 32'(lat), 32'd24);
    chk("b2b_res1", 32'(Resultado), 32'h000600);
    k = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge CLK);
      #1;
      k++;
      if (k == 1) start = 1'b0;
      if (done) got = 1'b1;
    end
    chk("b2b_gap", 32'(k), 32'd25);
    chk("b2b_res2", 32'(Resultado), 32'h000900);
    chk("b2b_ovf2", 32'(overflow), 32'd0);

    // Reset at CALC cycle 10 aborts the operation
    repeat (3) @(posedge CLK);
    issue(23'h000300, 23'h000200);
    repeat (10) @(posedge CLK);
    #3;
    Reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_res", 32'(Resultado), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (done) nd++;
    end
    chk("mrst_nodone", 32'(nd), 32'd0);
    chk("mrst_hold", 32'(Resultado), 32'd0);

    // Normal operation after reset
    issue(23'h7FFD00, 23'h000200);
    wait_done(lat, bsy);
    chk("post_lat", 32'(lat), 32'd24);
    chk("post_res", 32'(Resultado), 32'h7FFA00);
    chk("post_ovf", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
